// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared widths and types for the register file and the ALU units around it.
//   DATA_W     : operand / register width
//   ADDR_W     : register address width
//   NUM_REGS   : number of registers, always 2**ADDR_W
//   word_t     : one register / operand word
//   reg_addr_t : one register address
package reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_mem.sv
// reg_file_mem
// Register storage with one synchronous write port and two combinational
// read ports. A read that hits the address being written in the same cycle
// returns the incoming write data, so a consumer that registers the read
// sees the freshest value.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset (clears all regs)
//   we, waddr, wdata   : write port, applied at the rising edge
//   raddr_a, raddr_b   : read addresses
//   rdata_a, rdata_b   : bypassed read data
module reg_file_mem #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  import reg_file_pkg::*;

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Each read port independently forwards the write data on an address hit.
  always_comb begin
    rdata_a = mem_q[raddr_a];
    rdata_b = mem_q[raddr_b];
    if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
    if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule : reg_file_mem

// File: rtl/reg_file_issue.sv
// reg_file_issue
// Register file plus a single-entry operand-issue register feeding the ALU.
// A read request is accepted when the output slot is empty or being drained
// this cycle; the operands captured on acceptance appear one cycle later and
// are held unchanged (a snapshot) until the ALU takes them.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   we, waddr, wdata         : write-back port, applied every cycle
//   in_valid, in_ready       : read request handshake
//   raddr_a, raddr_b         : operand addresses of the request
//   op_valid, op_ready       : operand handshake towards the ALU
//   op_a, op_b               : registered operands
module reg_file_issue #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
);

  import reg_file_pkg::*;

  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              accept;
  logic              issue;

  reg_file_mem #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );

  // The slot can take a new pair if it is empty or is being consumed now.
  assign in_ready = !valid_q || op_ready;
  assign accept   = in_valid && in_ready;
  assign issue    = valid_q && op_ready;

  // Operands only change on accept, so a stalled pair ignores later writes.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = rdata_a;
      b_d     = rdata_b;
    end else if (issue) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign op_valid = valid_q;
  assign op_a     = a_q;
  assign op_b     = b_q;

endmodule : reg_file_issue

// File: tb/tb_reg_file_issue.sv
// tb_reg_file_issue
// Self-checking bench for reg_file_issue: directed scenarios plus a random
// phase, all compared against a behavioural register-file model.
module tb_reg_file_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [15:0] refMem [8];
  logic        refValid;
  logic [15:0] refA;
  logic [15:0] refB;
  logic        refReadyPre;
  logic        sawReady;

  always #5 clk = ~clk;

  reg_file_issue dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a    (op_a),
    .op_b    (op_b)
  );

  task automatic modelReset();
    for (int i = 0; i < 8; i++) refMem[i] = 16'h0000;
    refValid = 1'b0;
    refA     = 16'h0000;
    refB     = 16'h0000;
  endtask

  // Drives one cycle starting just after a rising edge, samples in_ready
  // before the next edge, advances the model at the edge, then settles.
  task automatic cycle(input logic iv, input logic [2:0] ra, input logic [2:0] rb,
                       input logic ordy, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd);
    logic acc;
    logic iss;
    in_valid = iv;
    raddr_a  = ra;
    raddr_b  = rb;
    op_ready = ordy;
    we       = w;
    waddr    = wa;
    wdata    = wd;
    #3;
    sawReady    = in_ready;
    refReadyPre = !refValid || ordy;
    acc = iv && refReadyPre;
    iss = refValid && ordy;
    @(posedge clk);
    if (acc) begin
      refA     = (w && wa == ra) ? wd : refMem[ra];
      refB     = (w && wa == rb) ? wd : refMem[rb];
      refValid = 1'b1;
    end else if (iss) begin
      refValid = 1'b0;
    end
    if (w) refMem[wa] = wd;
    #1;
  endtask

  task automatic writeReg(input logic [2:0] wa, input logic [15:0] wd);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, wa, wd);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    in_valid = 1'b0;
    raddr_a  = '0;
    raddr_b  = '0;
    op_ready = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", op_valid); end
    total++;
    if (op_a !== 16'h0000 || op_b !== 16'h0000) begin
      bad++; $display("[TB] FAIL reset_ops got=%h/%h exp=0000/0000", op_a, op_b);
    end
    cycle(1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 3'd0, 16'h0);
    total++;
    if (sawReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", sawReady); end
    total++;
    if (op_valid !== 1'b1 || op_a !== 16'h0000 || op_b !== 16'h0000) begin
      bad++; $display("[TB] FAIL reset_read got=%b %h %h exp=1 0000 0000", op_valid, op_a, op_b);
    end
  endtask

  task automatic test_basic_write();
    writeReg(3'd2, 16'hA5A5);
    cycle(1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 3'd0, 16'h0);
    total++;
    if (op_valid !== 1'b1 || op_a !== 16'hA5A5 || op_b !== 16'hA5A5) begin
      bad++; $display("[TB] FAIL basic_rw got=%b %h %h exp=1 a5a5 a5a5", op_valid, op_a, op_b);
    end
  endtask

  task automatic test_bypass();
    writeReg(3'd1, 16'h00FF);
    cycle(1'b1, 3'd4, 3'd1, 1'b1, 1'b1, 3'd4, 16'h1234);
    total++;
    if (op_a !== 16'h1234 || op_b !== 16'h00FF) begin
      bad++; $display("[TB] FAIL bypass got=%h %h exp=1234 00ff", op_a, op_b);
    end
    cycle(1'b1, 3'd7, 3'd7, 1'b1, 1'b1, 3'd7, 16'hC3C3);
    total++;
    if (op_a !== 16'hC3C3 || op_b !== 16'hC3C3) begin
      bad++; $display("[TB] FAIL bypass_both got=%h %h exp=c3c3 c3c3", op_a, op_b);
    end
  endtask

  task automatic test_stall_snapshot();
    writeReg(3'd6, 16'h0F0F);
    cycle(1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'd6, 3'd6, 1'b0, 1'b1, 3'd6, 16'hFFFF);
      total++;
      if (sawReady !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready got=%b exp=0", sawReady); end
      total++;
      if (op_valid !== 1'b1 || op_a !== 16'h0F0F) begin
        bad++; $display("[TB] FAIL stall_hold got=%b %h exp=1 0f0f", op_valid, op_a);
      end
    end
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_issue got=%b exp=0", op_valid); end
    cycle(1'b1, 3'd6, 3'd6, 1'b1, 1'b0, 3'd0, 16'h0);
    total++;
    if (op_valid !== 1'b1 || op_a !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL stall_reread got=%b %h exp=1 ffff", op_valid, op_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = 16'($urandom);
      writeReg(3'(i), vals[i]);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i), 3'(7 - i), 1'b1, 1'b0, 3'd0, 16'h0);
      total++;
      if (sawReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready[%0d] got=%b exp=1", i, sawReady); end
      total++;
      if (op_valid !== 1'b1 || op_a !== vals[i] || op_b !== vals[7 - i]) begin
        bad++; $display("[TB] FAIL b2b_ops[%0d] got=%b %h %h exp=1 %h %h", i, op_valid, op_a, op_b, vals[i], vals[7 - i]);
      end
    end
  endtask

  task automatic test_async_reset();
    writeReg(3'd3, 16'hBEEF);
    cycle(1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 3'd0, 16'h0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_valid got=%b exp=0", op_valid); end
    #1;
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    cycle(1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 3'd0, 16'h0);
    total++;
    if (op_valid !== 1'b1 || op_a !== 16'h0000 || op_b !== 16'h0000) begin
      bad++; $display("[TB] FAIL async_clear got=%b %h %h exp=1 0000 0000", op_valid, op_a, op_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 3'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), 3'($urandom), 16'($urandom));
      total++;
      if (sawReady !== refReadyPre) begin
        bad++; $display("[TB] FAIL rand_ready[%0d] got=%b exp=%b", i, sawReady, refReadyPre);
      end
      total++;
      if (op_valid !== refValid) begin
        bad++; $display("[TB] FAIL rand_valid[%0d] got=%b exp=%b", i, op_valid, refValid);
      end
      if (refValid) begin
        total++;
        if (op_a !== refA || op_b !== refB) begin
          bad++; $display("[TB] FAIL rand_ops[%0d] got=%h %h exp=%h %h", i, op_a, op_b, refA, refB);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bypass();
    test_stall_snapshot();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_issue
